// File: rtl/outport_uart_tx.sv
// outport_uart_tx: buffers bytes from the output strobe in a FIFO and sends each as an 8N1 frame on tx.
// Define OUTPORT_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module outport_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          tx,
  output logic                          tx_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`ifdef OUTPORT_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, state_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] head, tail;
  logic [7:0] data, data_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic last, pop, wr_ok, tx_d;

  assign full = count == CNTW'(FIFO_DEPTH);
  assign empty = count == '0;
  assign tx_busy = state != IDLE;
  assign wr_ok = wr_en && !full;
  assign last = cnt == CW'(CLKS_PER_BIT - 1);
  assign pop = !empty && (state == IDLE || (state == STOP && last));

  always_ff @(posedge clk)
    if (wr_ok) mem[tail] <= wr_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + CNTW'(wr_ok) - CNTW'(pop);
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      data <= '0;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      data <= data_n;
      tx <= tx_d;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = empty ? IDLE : START;
      START:   state_n = last ? DATA : START;
      DATA:    state_n = (last && bit_idx == 3'd7) ? AFTER_DATA : DATA;
      PARITY:  state_n = last ? STOP : PARITY;
      STOP:    state_n = !last ? STOP : empty ? IDLE : START;
      default: state_n = IDLE;
    endcase
    cnt_n = (state == IDLE || last) ? '0 : cnt + 1'b1;
    bit_n = (state == DATA) ? bit_idx + 3'(last) : '0;
    data_n = pop ? mem[head] : data;
  end

  // tx is computed from the next state so the line changes on the same edge as the FSM
  always_comb begin
    tx_d = state_n == START  ? 1'b0 :
           state_n == DATA   ? data_n[bit_n] :
           state_n == PARITY ? ^data_n : 1'b1;
  end
endmodule

// File: tb/tb_outport_uart_tx.sv
// tb_outport_uart_tx: random and directed writes checked against an occupancy/timing model and a tx-line frame decoder.
module tb_outport_uart_tx;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
`ifdef OUTPORT_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif
  logic clk = 0;
  logic reset = 0;
  logic wr_en = 0;
  logic [7:0] wr_data = 0;
  logic full, empty, overflow, tx, tx_busy;
  logic [2:0] count;
  int checks = 0;
  int errors = 0;
  int epoch = 0;
  logic [7:0] mq[$];
  logic [7:0] expq[$];
  int busy_left = 0;
  bit m_ovf = 0;

  outport_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Abstract model: a byte queue plus the number of cycles left in the current frame.
  task automatic model(input logic r, input logic w, input logic [7:0] d);
    bit pop, full_pre;
    if (!r) begin
      mq.delete();
      expq.delete();
      busy_left = 0;
      m_ovf = 0;
      epoch++;
    end else begin
      full_pre = mq.size() == DEPTH;
      pop = mq.size() > 0 && busy_left <= 1;
      if (w && full_pre) m_ovf = 1;
      if (w && !full_pre) begin
        mq.push_back(d);
        expq.push_back(d);
      end
      if (pop) begin
        void'(mq.pop_front());
        busy_left = FRAME;
      end else if (busy_left > 0) busy_left--;
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [7:0] d);
    @(negedge clk);
    reset = r;
    wr_en = w;
    wr_data = d;
    @(posedge clk);
    model(r, w, d);
    #1;
    chk("count", int'(count), mq.size());
    chk("full", int'(full), int'(mq.size() == DEPTH));
    chk("empty", int'(empty), int'(mq.size() == 0));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("tx_busy", int'(tx_busy), int'(busy_left > 0));
    if (busy_left == 0) chk("tx_idle", int'(tx), 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 8'h00);
  endtask

  // Frame decoder on the serial line, sampling near the middle of each bit.
  initial begin
    logic [7:0] b, ex;
    logic s0, st, p;
    int e;
    forever begin
      @(negedge clk);
      if (reset && tx === 1'b0) begin
        e = epoch;
        p = 0;
        repeat (CPB / 2) @(negedge clk);
        s0 = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
`ifdef OUTPORT_PARITY_EN
        repeat (CPB) @(negedge clk);
        p = tx;
`endif
        repeat (CPB) @(negedge clk);
        st = tx;
        if (e == epoch) begin
          if (expq.size() == 0) chk("unexpected_frame", 1, 0);
          else begin
            ex = expq.pop_front();
            chk("start_bit", int'(s0), 0);
            chk("data_byte", int'(b), int'(ex));
`ifdef OUTPORT_PARITY_EN
            chk("parity_bit", int'(p), int'(^ex));
`endif
            chk("stop_bit", int'(st), 1);
          end
        end
      end
    end
  end

  initial begin
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 1, 8'h5A);
    idle(2);
    step(1, 1, 8'hA5);
    idle(FRAME + 5);
    for (int i = 0; i < 6; i++) step(1, 1, 8'($urandom));
    idle(5 * FRAME + 10);
    step(1, 1, 8'h00);
    step(1, 1, 8'hFF);
    idle(2 * FRAME + 10);
`ifdef OUTPORT_PARITY_EN
    step(1, 1, 8'h07);
    step(1, 1, 8'h03);
    idle(2 * FRAME + 10);
`endif
    step(1, 1, 8'h3C);
    idle(18);
    step(0, 0, 8'h00);
    idle(FRAME + 10);
    for (int i = 0; i < 800; i++) step(1, $urandom_range(0, 9) < 2, 8'($urandom));
    idle(DEPTH * FRAME + FRAME + 10);
    chk("pending_frames", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
